cpu_boot_mem: RTL

Parametrised instruction/data memory pair for the accumulator CPU. It replaces direct flat-bus initialisation with a sequenced boot loader. After reset or a reload request, it copies the flat init_ins/init_data vectors word by word into two internal arrays. It then serves the CPU: one registered instruction read port, and one registered data read/write port. Sits between the top-level init buses and the CPU fetch/execute datapath (PC→ins_addr, AR→data_addr, AC→data_wdata).

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_mem_bank.sv | 46 ++++
 rtl/cpu_boot_mem.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU boot memory: default geometry,
// loader states and flat init-vector indexing.
package cpu_pkg;

    localparam int unsigned DEF_WORD_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;

    typedef logic [0:0] state_t;
    localparam state_t ST_LOAD = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Bit offset of word idx inside a flat vector of word_w-bit words.
    function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned word_w);
        return idx * word_w;
    endfunction

endpackage

// File: rtl/cpu_mem_bank.sv
// Single memory bank: one write port and one registered read port that
// returns zero when disabled or when the address is past the last word.
module cpu_mem_bank #(
    parameter  int unsigned WORD_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned       CMP_W   = ADDR_W + 1;
    localparam logic [CMP_W-1:0]  DEPTH_C = CMP_W'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic              rd_ok;
    logic              wr_ok;

    // One extra bit keeps the range compare meaningful for power-of-two depths.
    assign rd_ok = {1'b0, raddr} < DEPTH_C;
    assign wr_ok = {1'b0, waddr} < DEPTH_C;

    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first: a same-edge write to raddr is seen on the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re && rd_ok) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/cpu_boot_mem.sv
// Instruction/data memory pair with a sequenced boot loader that copies the
// flat init images into the banks before opening the CPU ports.
module cpu_boot_mem
    import cpu_pkg::*;
#(
    parameter  int unsigned WORD_W = DEF_WORD_W,
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned INIT_W = WORD_W * DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INIT_W-1:0] init_ins,
    input  logic [INIT_W-1:0] init_data,
    input  logic              reload,
    output logic              ready,
    output logic              load_done,
    input  logic [ADDR_W-1:0] ins_addr,
    output logic [WORD_W-1:0] ins_rdata,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_we,
    input  logic [WORD_W-1:0] data_wdata,
    output logic [WORD_W-1:0] data_rdata,
    output logic              access_err
);

    localparam int unsigned        OFF_W    = $clog2(INIT_W);
    localparam int unsigned        CMP_W    = ADDR_W + 1;
    localparam logic [CMP_W-1:0]   DEPTH_C  = CMP_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              ready_nxt, load_done_nxt, err_nxt;

    logic [OFF_W-1:0]  word_off;
    logic [WORD_W-1:0] ins_word, data_word;
    logic              ins_addr_ok, data_addr_ok;

    logic              ins_we, ins_re;
    logic              dbank_we, dbank_re;
    logic [ADDR_W-1:0] dbank_waddr;
    logic [WORD_W-1:0] dbank_wdata;

    assign word_off     = OFF_W'(word_lsb(32'(idx), WORD_W));
    assign ins_word     = init_ins[word_off +: WORD_W];
    assign data_word    = init_data[word_off +: WORD_W];
    assign ins_addr_ok  = {1'b0, ins_addr} < DEPTH_C;
    assign data_addr_ok = {1'b0, data_addr} < DEPTH_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            idx        <= '0;
            ready      <= 1'b0;
            load_done  <= 1'b0;
            access_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            ready      <= ready_nxt;
            load_done  <= load_done_nxt;
            access_err <= err_nxt;
        end
    end

    // Loader sequencing, CPU port gating and error tracking.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        ready_nxt     = ready;
        load_done_nxt = 1'b0;
        err_nxt       = access_err;
        ins_we        = 1'b0;
        ins_re        = 1'b0;
        dbank_we      = 1'b0;
        dbank_re      = 1'b0;
        dbank_waddr   = idx;
        dbank_wdata   = data_word;

        case (state)
            ST_LOAD: begin
                if (reload) begin
                    idx_nxt = '0;
                    err_nxt = 1'b0;
                end else begin
                    ins_we   = 1'b1;
                    dbank_we = 1'b1;
                    if (data_we) begin
                        err_nxt = 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state_nxt     = ST_RUN;
                        idx_nxt       = '0;
                        ready_nxt     = 1'b1;
                        load_done_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_nxt = ST_LOAD;
                    idx_nxt   = '0;
                    ready_nxt = 1'b0;
                    err_nxt   = 1'b0;
                end else begin
                    ins_re      = 1'b1;
                    dbank_re    = 1'b1;
                    dbank_waddr = data_addr;
                    dbank_wdata = data_wdata;
                    dbank_we    = data_we && data_addr_ok;
                    if (!ins_addr_ok || !data_addr_ok) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_LOAD;
                idx_nxt   = '0;
                ready_nxt = 1'b0;
            end
        endcase
    end

    // Instruction bank: written only by the loader.
    cpu_mem_bank #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_ins_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ins_we),
        .waddr (idx),
        .wdata (ins_word),
        .re    (ins_re),
        .raddr (ins_addr),
        .rdata (ins_rdata)
    );

    cpu_mem_bank #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_data_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (dbank_we),
        .waddr (dbank_waddr),
        .wdata (dbank_wdata),
        .re    (dbank_re),
        .raddr (data_addr),
        .rdata (data_rdata)
    );

endmodule
